hazard_controller: RTL and testbench
====================================

Name: hazard_controller

Overview:
- Pipeline sequencing controller for the 5-stage vector ASIP (fetch, decode, execute, memory, writeback).
- Generates hold, bubble and flush controls for the PC, PipelineFetch, PipelineMem and PipelineEx registers from three events:
  - load-use hazards between the decode and execute stages;
  - multi-cycle 128-bit vector memory accesses;
  - taken jumps resolved in execute.
- Also keeps saturating stall and flush event counters for debug.

Parameters:
- REG_AW, 4: register/vector-register index width.
- MEM_VEC_CYCLES, 4: total cycles a vector (VF=1) memory access occupies the memory stage; minimum 1.
- CNT_W, 16: width of the event counters.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: synchronous, active-low reset.
- dec_src_a, input, REG_AW: decode-stage first source index (R2_V2_D).
- dec_src_b, input, REG_AW: decode-stage second source index (R3_V3_D).
- dec_use_a, input, 1: decode instruction reads dec_src_a.
- dec_use_b, input, 1: decode instruction reads dec_src_b.
- dec_vf, input, 1: decode instruction is vector.
- ex_rmem, input, 1: execute-stage instruction is a load.
- ex_wreg, input, 1: execute-stage instruction writes a register.
- ex_dest, input, REG_AW: execute-stage destination index.
- ex_vf, input, 1: execute-stage instruction is vector.
- jmp_taken, input, 1: JmpSel from execute.
- mem_rmem, input, 1: memory-stage instruction reads memory.
- mem_wmem, input, 1: memory-stage instruction writes memory.
- mem_vf, input, 1: memory-stage instruction is vector.
- hold_pc, output, 1: freeze PC.
- hold_if, output, 1: freeze PipelineFetch.
- flush_if, output, 1: clear PipelineFetch to NOP.
- hold_id, output, 1: freeze PipelineMem.
- bubble_ex, output, 1: load NOP into PipelineMem.
- hold_ex, output, 1: freeze PipelineEx and the execute stage.
- stall_cnt, output, CNT_W: total stall cycles.
- flush_cnt, output, CNT_W: total flushes.

Behaviour:
- Reset: when rst=0 at a clk edge:
  - state goes to RUN;
  - all outputs 0, counters 0;
  - wait counter 0.
  - Reset mid-MEM_WAIT aborts the wait immediately.
- States: RUN, MEM_WAIT. Output decode is combinational from state and inputs.
- Hazard definitions:
  - Load-use hazard (lu): ex_rmem & ex_wreg & (ex_vf==dec_vf) & ((dec_use_a & dec_src_a==ex_dest) | (dec_use_b & dec_src_b==ex_dest)).
  - Vector memory access (vm): mem_vf & (mem_rmem|mem_wmem).
- RUN, priority jump > vector memory > load-use:
  - vm & MEM_VEC_CYCLES>1:
    - hold_pc=hold_if=hold_id=hold_ex=1;
    - go to MEM_WAIT with wait counter = MEM_VEC_CYCLES-2;
    - a jmp_taken or lu in the same cycle is deferred; inputs stay frozen, so it is re-evaluated on release.
  - else if jmp_taken: flush_if=1 and bubble_ex=1 for exactly one cycle, no hold; flush_cnt +1.
  - else if lu: hold_pc=hold_if=1 and bubble_ex=1 for one cycle. The next cycle re-evaluates; the load has left execute, so no repeat stall occurs.
  - else: all controls 0.
- MEM_WAIT:
  - All four holds are asserted every cycle.
  - Counter decrements each cycle; at 0, return to RUN.
  - Total frozen cycles = MEM_VEC_CYCLES-1. The instruction occupies the memory stage MEM_VEC_CYCLES cycles.
  - jmp_taken, lu and vm are ignored in this state.
- Scalar memory accesses and MEM_VEC_CYCLES=1 never enter MEM_WAIT.
- Output exclusivity: flush_if and hold_if are never both 1; bubble_ex and hold_id are never both 1.
- stall_cnt increments on every cycle where hold_pc=1.
- Both counters saturate at all-ones and never wrap.

Decomposition:
- Package hazard_pkg holds:
  - state enum (RUN, MEM_WAIT);
  - a packed struct of the six pipeline control outputs;
  - NOP control constant.
- Sub-module hazard_event_counter: saturating CNT_W counter with synchronous active-low clear, instantiated twice (stall and flush).

Test Plan:
- Load-use, scalar:
  - stimulus: ex_rmem=1, ex_wreg=1, ex_dest=5, ex_vf=0, dec_use_a=1, dec_src_a=5, dec_vf=0;
  - required: one cycle of hold_pc=hold_if=bubble_ex=1, then all 0; stall_cnt=1.
- VF mismatch:
  - stimulus: same as load-use but dec_vf=1;
  - required: no stall.
- Vector load, MEM_VEC_CYCLES=4:
  - stimulus: mem_vf=1, mem_rmem=1;
  - required: holds asserted exactly 3 consecutive cycles, then RUN; stall_cnt=3.
- Jump deferred behind vector store:
  - stimulus: vm and jmp_taken in the same cycle;
  - required: 3 hold cycles, then flush_if=bubble_ex=1 on the release cycle; flush_cnt=1.
- Reset mid-wait:
  - stimulus: rst=0 on the second MEM_WAIT cycle;
  - required: next cycle all outputs 0, counters 0, state RUN.
- Saturation:
  - stimulus: CNT_W=4, 20 consecutive jumps;
  - required: flush_cnt holds at 15.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller: FSM states and the pipeline control bundle.
// Pure definitions; no logic, no latency, no backpressure.
package hazard_pkg;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } hz_state_t;

    typedef struct packed {
        logic hold_pc;
        logic hold_if;
        logic flush_if;
        logic hold_id;
        logic bubble_ex;
        logic hold_ex;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/hazard_controller_if.sv
// Hazard controller bus: pipeline-stage status in, hold/bubble/flush controls and debug counters out.
// Wires only; the pipeline side is master, the controller is slave.
interface hazard_controller_if #(
    parameter int REG_AW = 4,
    parameter int CNT_W  = 16
);
    logic [REG_AW-1:0] dec_src_a;
    logic [REG_AW-1:0] dec_src_b;
    logic              dec_use_a;
    logic              dec_use_b;
    logic              dec_vf;
    logic              ex_rmem;
    logic              ex_wreg;
    logic [REG_AW-1:0] ex_dest;
    logic              ex_vf;
    logic              jmp_taken;
    logic              mem_rmem;
    logic              mem_wmem;
    logic              mem_vf;
    logic              hold_pc;
    logic              hold_if;
    logic              flush_if;
    logic              hold_id;
    logic              bubble_ex;
    logic              hold_ex;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;

    modport master (
        output dec_src_a, dec_src_b, dec_use_a, dec_use_b, dec_vf,
               ex_rmem, ex_wreg, ex_dest, ex_vf, jmp_taken,
               mem_rmem, mem_wmem, mem_vf,
        input  hold_pc, hold_if, flush_if, hold_id, bubble_ex, hold_ex,
               stall_cnt, flush_cnt
    );

    modport slave (
        input  dec_src_a, dec_src_b, dec_use_a, dec_use_b, dec_vf,
               ex_rmem, ex_wreg, ex_dest, ex_vf, jmp_taken,
               mem_rmem, mem_wmem, mem_vf,
        output hold_pc, hold_if, flush_if, hold_id, bubble_ex, hold_ex,
               stall_cnt, flush_cnt
    );

endinterface

// File: rtl/hazard_event_counter.sv
// Saturating event counter with synchronous active-low clear; count visible one cycle after inc.
// No backpressure: inc is sampled every cycle and ignored once the counter is all-ones.
module hazard_event_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            cnt <= '0;
        end else if (inc && (cnt != {CNT_W{1'b1}})) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/hazard_controller.sv
// Pipeline hazard sequencer: combinational hold/bubble/flush controls (0-cycle latency) plus debug counters.
// Vector memory accesses freeze the pipe MEM_VEC_CYCLES-1 cycles; jumps and load-use wait behind them.
module hazard_controller
    import hazard_pkg::*;
#(
    parameter int REG_AW         = 4,
    parameter int MEM_VEC_CYCLES = 4,
    parameter int CNT_W          = 16
) (
    input  logic               clk,
    input  logic               rst,
    hazard_controller_if.slave hz
);

    localparam int                WAIT_W    = (MEM_VEC_CYCLES > 1) ? $clog2(MEM_VEC_CYCLES + 1) : 1;
    localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'((MEM_VEC_CYCLES > 1) ? MEM_VEC_CYCLES - 2 : 0);
    localparam logic              VEC_STALL = (MEM_VEC_CYCLES > 1);

    hz_state_t         state;
    logic [WAIT_W-1:0] wait_cnt;
    logic              just_freed;
    ctrl_t             ctrl;

    logic [REG_AW-1:0] src_a;
    logic [REG_AW-1:0] src_b;
    logic [REG_AW-1:0] dest;
    logic              lu;
    logic              vm;
    logic              vm_go;

    assign src_a = hz.dec_src_a;
    assign src_b = hz.dec_src_b;
    assign dest  = hz.ex_dest;

    assign lu = hz.ex_rmem & hz.ex_wreg & (hz.ex_vf == hz.dec_vf) &
                ((hz.dec_use_a & (src_a == dest)) | (hz.dec_use_b & (src_b == dest)));
    assign vm = hz.mem_vf & (hz.mem_rmem | hz.mem_wmem);

    // The vector op still sits in memory on its release cycle; it must not restart the freeze.
    assign vm_go = vm & ~just_freed & VEC_STALL;

    always_comb begin
        ctrl = CTRL_NOP;
        if (rst) begin
            case (state)
                RUN: begin
                    if (vm_go) begin
                        ctrl.hold_pc = 1'b1;
                        ctrl.hold_if = 1'b1;
                        ctrl.hold_id = 1'b1;
                        ctrl.hold_ex = 1'b1;
                    end else if (hz.jmp_taken) begin
                        ctrl.flush_if  = 1'b1;
                        ctrl.bubble_ex = 1'b1;
                    end else if (lu) begin
                        ctrl.hold_pc   = 1'b1;
                        ctrl.hold_if   = 1'b1;
                        ctrl.bubble_ex = 1'b1;
                    end
                end
                MEM_WAIT: begin
                    ctrl.hold_pc = 1'b1;
                    ctrl.hold_if = 1'b1;
                    ctrl.hold_id = 1'b1;
                    ctrl.hold_ex = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= RUN;
            wait_cnt   <= '0;
            just_freed <= 1'b0;
        end else begin
            just_freed <= 1'b0;
            case (state)
                RUN: begin
                    if (vm_go) begin
                        if (WAIT_INIT == '0) begin
                            just_freed <= 1'b1;
                        end else begin
                            state    <= MEM_WAIT;
                            wait_cnt <= WAIT_INIT;
                        end
                    end
                end
                MEM_WAIT: begin
                    // wait_cnt counts remaining frozen cycles including this one.
                    wait_cnt <= wait_cnt - WAIT_W'(1);
                    if (wait_cnt == WAIT_W'(1)) begin
                        state      <= RUN;
                        just_freed <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign hz.hold_pc   = ctrl.hold_pc;
    assign hz.hold_if   = ctrl.hold_if;
    assign hz.flush_if  = ctrl.flush_if;
    assign hz.hold_id   = ctrl.hold_id;
    assign hz.bubble_ex = ctrl.bubble_ex;
    assign hz.hold_ex   = ctrl.hold_ex;

    hazard_event_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .clr_n (rst),
        .inc   (ctrl.hold_pc),
        .cnt   (hz.stall_cnt)
    );

    hazard_event_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .clr_n (rst),
        .inc   (ctrl.flush_if),
        .cnt   (hz.flush_cnt)
    );

endmodule

// File: tb/tb_hazard_controller.sv
// Scoreboard bench for hazard_controller: directed scenarios plus random traffic against a cycle-level model.
// A second instance with 4-bit counters exercises counter saturation.
module tb_hazard_controller;

    localparam int MVC = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hazard_controller_if #(.REG_AW(4), .CNT_W(16)) hz ();
    hazard_controller_if #(.REG_AW(4), .CNT_W(4))  hz4 ();

    assign hz4.dec_src_a = hz.dec_src_a;
    assign hz4.dec_src_b = hz.dec_src_b;
    assign hz4.dec_use_a = hz.dec_use_a;
    assign hz4.dec_use_b = hz.dec_use_b;
    assign hz4.dec_vf    = hz.dec_vf;
    assign hz4.ex_rmem   = hz.ex_rmem;
    assign hz4.ex_wreg   = hz.ex_wreg;
    assign hz4.ex_dest   = hz.ex_dest;
    assign hz4.ex_vf     = hz.ex_vf;
    assign hz4.jmp_taken = hz.jmp_taken;
    assign hz4.mem_rmem  = hz.mem_rmem;
    assign hz4.mem_wmem  = hz.mem_wmem;
    assign hz4.mem_vf    = hz.mem_vf;

    hazard_controller #(.REG_AW(4), .MEM_VEC_CYCLES(MVC), .CNT_W(16)) dut (
        .clk (clk), .rst (rst), .hz (hz)
    );

    hazard_controller #(.REG_AW(4), .MEM_VEC_CYCLES(MVC), .CNT_W(4)) dut4 (
        .clk (clk), .rst (rst), .hz (hz4)
    );

    typedef struct packed {
        logic       rst;
        logic [3:0] src_a;
        logic [3:0] src_b;
        logic       use_a;
        logic       use_b;
        logic       dec_vf;
        logic       ex_rmem;
        logic       ex_wreg;
        logic [3:0] ex_dest;
        logic       ex_vf;
        logic       jmp;
        logic       mem_rmem;
        logic       mem_wmem;
        logic       mem_vf;
    } stim_t;

    // ctrl bit order: hold_pc, hold_if, flush_if, hold_id, bubble_ex, hold_ex
    typedef struct {
        logic [5:0] ctrl;
        int         stall;
        int         flush;
        int         flush4;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    int   freeze_left = 0;
    bit   freed       = 1'b0;
    int   stall_m     = 0;
    int   flush_m     = 0;
    int   flush4_m    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    function automatic stim_t idle();
        stim_t s;
        s     = '0;
        s.rst = 1'b1;
        return s;
    endfunction

    // Behavioural reference: counts remaining frozen cycles instead of tracking FSM state.
    function automatic exp_t model(input stim_t s);
        exp_t x;
        bit   lu;
        bit   vm;
        bit   suppress;
        x.ctrl   = 6'b000000;
        x.stall  = stall_m;
        x.flush  = flush_m;
        x.flush4 = flush4_m;
        lu = s.ex_rmem && s.ex_wreg && (s.ex_vf == s.dec_vf) &&
             ((s.use_a && s.src_a == s.ex_dest) || (s.use_b && s.src_b == s.ex_dest));
        vm = s.mem_vf && (s.mem_rmem || s.mem_wmem);
        if (!s.rst) begin
            freeze_left = 0;
            freed       = 1'b0;
            stall_m     = 0;
            flush_m     = 0;
            flush4_m    = 0;
        end else begin
            if (freeze_left > 0) begin
                x.ctrl = 6'b110101;
                freeze_left--;
                if (freeze_left == 0) freed = 1'b1;
            end else begin
                suppress = freed;
                freed    = 1'b0;
                if (vm && !suppress && MVC > 1) begin
                    x.ctrl      = 6'b110101;
                    freeze_left = MVC - 2;
                    if (freeze_left == 0) freed = 1'b1;
                end else if (s.jmp) begin
                    x.ctrl = 6'b001010;
                end else if (lu) begin
                    x.ctrl = 6'b110010;
                end
            end
            if (x.ctrl[5] && stall_m < 65535) stall_m++;
            if (x.ctrl[3] && flush_m < 65535) flush_m++;
            if (x.ctrl[3] && flush4_m < 15)   flush4_m++;
        end
        return x;
    endfunction

    task automatic cyc(input stim_t s);
        @(posedge clk);
        #1;
        rst          = s.rst;
        hz.dec_src_a = s.src_a;
        hz.dec_src_b = s.src_b;
        hz.dec_use_a = s.use_a;
        hz.dec_use_b = s.use_b;
        hz.dec_vf    = s.dec_vf;
        hz.ex_rmem   = s.ex_rmem;
        hz.ex_wreg   = s.ex_wreg;
        hz.ex_dest   = s.ex_dest;
        hz.ex_vf     = s.ex_vf;
        hz.jmp_taken = s.jmp;
        hz.mem_rmem  = s.mem_rmem;
        hz.mem_wmem  = s.mem_wmem;
        hz.mem_vf    = s.mem_vf;
        sb_q.push_back(model(s));
    endtask

    task automatic do_reset();
        stim_t s;
        s     = '0;
        s.rst = 1'b0;
        cyc(s);
    endtask

    always @(negedge clk) begin
        if (sb_q.size() != 0) begin
            mon_e = sb_q.pop_front();
            chk("ctrl", {26'd0, hz.hold_pc, hz.hold_if, hz.flush_if, hz.hold_id, hz.bubble_ex, hz.hold_ex},
                {26'd0, mon_e.ctrl});
            chk("stall_cnt", {16'd0, hz.stall_cnt}, mon_e.stall);
            chk("flush_cnt", {16'd0, hz.flush_cnt}, mon_e.flush);
            chk("flush_cnt_w4", {28'd0, hz4.flush_cnt}, mon_e.flush4);
            chk("exclusive", {31'd0, (hz.flush_if & hz.hold_if) | (hz.bubble_ex & hz.hold_id)}, 0);
        end
    end

    initial begin
        stim_t s;
        rst = 1'b0;
        hz.dec_src_a = '0; hz.dec_src_b = '0; hz.dec_use_a = 1'b0; hz.dec_use_b = 1'b0;
        hz.dec_vf = 1'b0; hz.ex_rmem = 1'b0; hz.ex_wreg = 1'b0; hz.ex_dest = '0;
        hz.ex_vf = 1'b0; hz.jmp_taken = 1'b0; hz.mem_rmem = 1'b0; hz.mem_wmem = 1'b0;
        hz.mem_vf = 1'b0;
        repeat (2) @(posedge clk);
        do_reset();
        do_reset();

        // Scalar load-use: one stall cycle
        s = idle(); s.ex_rmem = 1'b1; s.ex_wreg = 1'b1; s.ex_dest = 4'd5;
        s.use_a = 1'b1; s.src_a = 4'd5;
        cyc(s);
        cyc(idle());
        cyc(idle());
        @(negedge clk);
        chk("lu_stall_total", {16'd0, hz.stall_cnt}, 1);

        // Vector/scalar mismatch: no stall
        do_reset();
        s.dec_vf = 1'b1;
        cyc(s);
        cyc(idle());
        @(negedge clk);
        chk("vf_mismatch_stall", {16'd0, hz.stall_cnt}, 0);

        // Vector load held in memory for MVC cycles
        do_reset();
        s = idle(); s.mem_vf = 1'b1; s.mem_rmem = 1'b1;
        repeat (MVC) cyc(s);
        cyc(idle());
        @(negedge clk);
        chk("vec_load_stall_total", {16'd0, hz.stall_cnt}, 3);

        // Jump arriving together with a vector store waits for release
        do_reset();
        s = idle(); s.mem_vf = 1'b1; s.mem_wmem = 1'b1; s.jmp = 1'b1;
        repeat (MVC) cyc(s);
        cyc(idle());
        @(negedge clk);
        chk("deferred_jmp_flush", {16'd0, hz.flush_cnt}, 1);
        chk("deferred_jmp_stall", {16'd0, hz.stall_cnt}, 3);

        // Reset on the second MEM_WAIT cycle
        do_reset();
        s = idle(); s.mem_vf = 1'b1; s.mem_rmem = 1'b1;
        cyc(s);
        cyc(s);
        s.rst = 1'b0;
        cyc(s);
        cyc(idle());
        @(negedge clk);
        chk("post_reset_hold", {31'd0, hz.hold_pc}, 0);
        chk("post_reset_stall", {16'd0, hz.stall_cnt}, 0);

        // 20 jumps: 4-bit counter pins at 15
        do_reset();
        s = idle(); s.jmp = 1'b1;
        repeat (20) cyc(s);
        cyc(idle());
        @(negedge clk);
        chk("flush_sat_w4", {28'd0, hz4.flush_cnt}, 15);
        chk("flush_w16", {16'd0, hz.flush_cnt}, 20);

        // Random traffic
        do_reset();
        for (int i = 0; i < 600; i++) begin
            s          = idle();
            s.rst      = ($urandom_range(99) != 0);
            s.src_a    = 4'($urandom_range(3));
            s.src_b    = 4'($urandom_range(3));
            s.ex_dest  = 4'($urandom_range(3));
            s.use_a    = 1'($urandom_range(1));
            s.use_b    = 1'($urandom_range(1));
            s.dec_vf   = 1'($urandom_range(1));
            s.ex_vf    = 1'($urandom_range(1));
            s.ex_rmem  = 1'($urandom_range(1));
            s.ex_wreg  = 1'($urandom_range(1));
            s.jmp      = ($urandom_range(5) == 0);
            s.mem_vf   = ($urandom_range(3) == 0);
            s.mem_rmem = 1'($urandom_range(1));
            s.mem_wmem = 1'($urandom_range(1));
            cyc(s);
        end
        cyc(idle());
        @(negedge clk);
        @(negedge clk);
        chk("scoreboard_drained", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
